// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive character FIFO (FWFT) with capture FSM, overrun and irq level
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   clr             synchronous flush, also clears overrun
//   rx_done         receiver done level (one character per high episode)
//   rx_data         receiver data byte, stable while rx_done high
//   rx_err          receiver framing error, valid one cycle after rx_done rises
//   rd_en           single-cycle pop strobe
//   irq_thresh      interrupt level threshold (0 treated as 1)
//   rd_data/rd_err  head entry, forced to 0 while empty
//   empty/full/count occupancy status
//   overrun         sticky: character dropped because FIFO was full
//   rx_irq          count >= irq_thresh and not empty
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              rx_done,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_err,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   irq_thresh,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    output logic              rx_irq
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W:0]   mem [DEPTH];
    logic [DATA_W:0]   head;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   thresh_eff;
    logic              ovr;
    logic              capture;
    logic              do_pop;
    logic              do_push;
    logic              drop;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (rx_done) state_nxt = CAPTURE;
            CAPTURE:  state_nxt = WAIT_LOW;
            WAIT_LOW: if (!rx_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign count   = cnt;
    assign overrun = ovr;

    // A pop in the capture cycle frees the slot the incoming character needs.
    assign capture = (state == CAPTURE);
    assign do_pop  = rd_en && !empty;
    assign do_push = capture && (!full || do_pop);
    assign drop    = capture && full && !do_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovr    <= 1'b0;
        end else if (clr) begin
            // A character still signalled on rx_done must not be captured again.
            state  <= rx_done ? WAIT_LOW : IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovr    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
            if (drop) ovr <= 1'b1;
        end
    end

    // Storage is not reset; outputs are gated while empty instead.
    always_ff @(posedge clk) begin
        if (rst_n && !clr && do_push) mem[wr_ptr] <= {rx_err, rx_data};
    end

    assign head       = mem[rd_ptr];
    assign rd_data    = empty ? '0 : head[DATA_W-1:0];
    assign rd_err     = !empty && head[DATA_W];
    assign thresh_eff = (irq_thresh == '0) ? CNT_ONE : irq_thresh;
    assign rx_irq     = !empty && (cnt >= thresh_eff);

endmodule
